// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers (reduction polynomial x^8+x^4+x^3+x+1).
package aes_pkg;

  localparam logic [7:0]  AES_POLY        = 8'h1B;
  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned AES_COL_BYTES   = 4;
  localparam int unsigned AES_COL_W       = 8 * AES_COL_BYTES;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  // Inverse-matrix coefficients built from the x2/x4/x8 chain
  function automatic logic [7:0] gmul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/mix_column_comb.sv
// Combinational MixColumns (or InvMixColumns) of one 32-bit column, row 0 in bits [31:24].
module mix_column_comb
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [AES_COL_W-1:0] i_col,
  input  logic                 i_bypass,
  output logic [AES_COL_W-1:0] o_col_c
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  // One output row: a is the same-row byte, b/c/d the following rows mod 4
  function automatic logic [7:0] mix_row(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
    if (INVERSE) return gmule(a) ^ gmulb(b) ^ gmuld(c) ^ gmul9(d);
    else         return gmul2(a) ^ gmul3(b) ^ c ^ d;
  endfunction

  always_comb begin
    o_col_c = i_col;
    if (!i_bypass) begin
      o_col_c = {mix_row(w_a0, w_a1, w_a2, w_a3),
                 mix_row(w_a1, w_a2, w_a3, w_a0),
                 mix_row(w_a2, w_a3, w_a0, w_a1),
                 mix_row(w_a3, w_a0, w_a1, w_a2)};
    end
  end

endmodule

// File: rtl/mix_columns_serial.sv
// Byte-serial MixColumns: gathers 4-byte columns, mixes them, and re-emits
// them one byte per cycle starting the cycle after the column completes.
module mix_columns_serial
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  input  logic       bypass,
  output logic [7:0] data_out,
  output logic       out_valid,
  output logic       out_last
);

  localparam int unsigned ROW_W = $clog2(AES_COL_BYTES);
  localparam int unsigned BLK_W = $clog2(AES_BLOCK_BYTES);

  logic [ROW_W-1:0]     r_row;
  logic [BLK_W-1:0]     r_iblk;
  logic [BLK_W-1:0]     r_oblk;
  logic [2:0]           r_drain;
  logic [23:0]          r_col;
  logic [23:0]          r_out;
  logic [AES_COL_W-1:0] w_col;
  logic [AES_COL_W-1:0] w_mix;
  logic                 w_load;
  logic                 w_emit;

  assign w_col  = {r_col, data_in};
  assign w_load = in_valid && (r_row == ROW_W'(AES_COL_BYTES - 1));
  assign w_emit = w_load || (r_drain > 3'd1);

  mix_column_comb #(.INVERSE(INVERSE)) u_mix (
    .i_col    (w_col),
    .i_bypass (bypass),
    .o_col_c  (w_mix)
  );

  // Input side: row/block counters and the collect shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_iblk <= '0;
      r_col  <= '0;
    end else if (in_valid) begin
      r_row  <= r_row + ROW_W'(1);
      r_iblk <= r_iblk + BLK_W'(1);
      r_col  <= {r_col[15:0], data_in};
    end
  end

  // Output side: r0 goes straight to data_out on load, r1..r3 drain from r_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain   <= '0;
      r_out     <= '0;
      r_oblk    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= w_emit;
      out_last  <= w_emit && (r_oblk == BLK_W'(AES_BLOCK_BYTES - 1));
      if (w_emit) r_oblk <= r_oblk + BLK_W'(1);
      if (w_load) begin
        r_drain  <= 3'd4;
        data_out <= w_mix[31:24];
        r_out    <= w_mix[23:0];
      end else if (r_drain != 3'd0) begin
        r_drain <= r_drain - 3'd1;
        if (r_drain > 3'd1) begin
          data_out <= r_out[23:16];
          r_out    <= {r_out[15:0], 8'h00};
        end
      end
    end
  end

  // A new column can only complete once the previous one is down to its last byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_load && (r_drain > 3'd1)))
        else $error("mix_columns_serial: column load while drain=%0d", r_drain);
      assert (r_iblk[ROW_W-1:0] == r_row)
        else $error("mix_columns_serial: row/block counters out of step");
    end
  end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Bench for mix_columns_serial: column vector table driven through a
// cycle-stamped scoreboard, plus inverse-matrix and reset corner sequences.
module tb_mix_columns_serial;

  typedef struct packed {
    logic [31:0] din;
    logic        byp;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       bypass = 1'b0;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_last;

  logic [7:0] inv_data_in = 8'h00;
  logic       inv_in_valid = 1'b0;
  logic       inv_bypass = 1'b0;
  logic [7:0] inv_data_out;
  logic       inv_out_valid;
  logic       inv_out_last;

  int   errors = 0;
  int   checks = 0;
  int   n = 0;
  int   ocnt = 0;
  bit   mon_en = 1'b0;
  sb_t  q[$];
  vec_t vecs[9];

  mix_columns_serial #(.INVERSE(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .bypass    (bypass),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  mix_columns_serial #(.INVERSE(1'b1)) dut_inv (
    .clk       (clk),
    .rst       (rst),
    .data_in   (inv_data_in),
    .in_valid  (inv_in_valid),
    .bypass    (inv_bypass),
    .data_out  (inv_data_out),
    .out_valid (inv_out_valid),
    .out_last  (inv_out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Monitor: every valid output byte must match the queue head, on its exact cycle
  always @(posedge clk) begin
    sb_t e;
    n++;
    #1;
    if (mon_en) begin
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("out_cycle", 32'(n), 32'(e.cyc));
          chk("data_out", 32'(data_out), 32'(e.data));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end else begin
        if (q.size() != 0 && q[0].cyc <= n) begin
          e = q.pop_front();
          chk("missing_valid", 32'(out_valid), 32'd1);
        end
        if (out_last !== 1'b0) chk("last_without_valid", 32'(out_last), 32'd0);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Drive one column; gmax>0 inserts 1..gmax idle cycles before bytes 1..3
  task automatic send_col(input vec_t v, input int gmax);
    sb_t e;
    for (int k = 0; k < 4; k++) begin
      if (gmax > 0 && k > 0) idle(int'($urandom_range(gmax, 1)));
      @(negedge clk);
      data_in  = v.din[8*(3-k) +: 8];
      in_valid = 1'b1;
      bypass   = v.byp;
    end
    for (int j = 0; j < 4; j++) begin
      e.data = v.exp[8*(3-j) +: 8];
      e.last = (ocnt == 15);
      e.cyc  = n + 1 + j;
      ocnt   = (ocnt + 1) % 16;
      q.push_back(e);
    end
  endtask

  // Synchronous reset with a byte presented in the same cycle; that byte must be dropped
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'hA5;
    q.delete();
    ocnt = 0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
  endtask

  initial begin
    logic [31:0] inv_in;
    logic [31:0] inv_exp;

    vecs[0] = '{din: 32'hdb135345, byp: 1'b0, exp: 32'h8e4da1bc};
    vecs[1] = '{din: 32'hf20a225c, byp: 1'b0, exp: 32'h9fdc589d};
    vecs[2] = '{din: 32'h01010101, byp: 1'b0, exp: 32'h01010101};
    vecs[3] = '{din: 32'hc6c6c6c6, byp: 1'b0, exp: 32'hc6c6c6c6};
    vecs[4] = '{din: 32'hd4bf5d30, byp: 1'b0, exp: 32'h046681e5};
    vecs[5] = '{din: 32'hf20a225c, byp: 1'b1, exp: 32'hf20a225c};
    vecs[6] = '{din: 32'h01010101, byp: 1'b1, exp: 32'h01010101};
    vecs[7] = '{din: 32'hc6c6c6c6, byp: 1'b1, exp: 32'hc6c6c6c6};
    vecs[8] = '{din: 32'hd4bf5d30, byp: 1'b1, exp: 32'hd4bf5d30};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_data_out", 32'(data_out), 32'd0);
    chk("init_out_last", 32'(out_last), 32'd0);
    mon_en = 1'b1;

    // Single column, continuous
    send_col(vecs[0], 0);
    idle(6);

    // Four columns back to back: mixed, then bypassed, then with random gaps
    do_reset();
    for (int i = 1; i <= 4; i++) send_col(vecs[i], 0);
    idle(6);
    do_reset();
    for (int i = 5; i <= 8; i++) send_col(vecs[i], 0);
    idle(6);
    do_reset();
    for (int i = 1; i <= 4; i++) send_col(vecs[i], 3);
    idle(6);

    // Inverse instance undoes the forward result
    inv_in  = 32'h8e4da1bc;
    inv_exp = 32'hdb135345;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      inv_data_in  = inv_in[8*(3-k) +: 8];
      inv_in_valid = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      inv_in_valid = 1'b0;
      chk("inv_out_valid", 32'(inv_out_valid), 32'd1);
      chk("inv_data_out", 32'(inv_data_out), 32'(inv_exp[8*(3-k) +: 8]));
    end
    @(negedge clk);
    chk("inv_valid_after", 32'(inv_out_valid), 32'd0);

    // Reset after two bytes of a column; the next four bytes are a fresh column
    @(negedge clk);
    data_in = 8'h11; in_valid = 1'b1; bypass = 1'b0;
    @(negedge clk);
    data_in = 8'h22;
    do_reset();
    send_col(vecs[0], 0);
    idle(1);
    idle(1);
    // Reset while r2/r3 are still draining
    do_reset();
    idle(3);
    for (int i = 1; i <= 4; i++) send_col(vecs[i], 0);
    idle(2);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
